// File: rtl/cfo_nco.sv
// cfo_nco: frame-atomic phase generator and sample aligner feeding the CFO
// rotator. Each valid two-antenna sample leaves one cycle later together with
// its compensation phase; the phase slope only changes at a frame boundary.
module cfo_nco #(
  parameter int DATA_W  = 16,
  parameter int PHASE_W = 16,
  parameter int FREQ_W  = 20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      freq_valid,
  input  logic signed [FREQ_W-1:0]  freq_word,
  input  logic                      nco_clear,
  input  logic                      in_valid,
  input  logic                      frame_start,
  input  logic signed [DATA_W-1:0]  in1_re,
  input  logic signed [DATA_W-1:0]  in1_im,
  input  logic signed [DATA_W-1:0]  in2_re,
  input  logic signed [DATA_W-1:0]  in2_im,
  output logic                      out_valid,
  output logic signed [DATA_W-1:0]  out1_re,
  output logic signed [DATA_W-1:0]  out1_im,
  output logic signed [DATA_W-1:0]  out2_re,
  output logic signed [DATA_W-1:0]  out2_im,
  output logic signed [PHASE_W-1:0] phase_out,
  output logic                      locked
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [FREQ_W-1:0] acc;
  logic [FREQ_W-1:0] freq_reg;
  logic [FREQ_W-1:0] pend_word;
  logic              pend_flag;
  logic [FREQ_W-1:0] f_eff;

  // Increment adopted at a frame boundary: a coincident estimate bypasses the
  // pending register, otherwise the pending one wins over the active one.
  always_comb begin
    f_eff = freq_reg;
    if (freq_valid) begin
      f_eff = freq_word;
    end else if (pend_flag) begin
      f_eff = pend_word;
    end
  end

  // Control state, accumulator and registered output bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      locked    <= 1'b0;
      acc       <= '0;
      freq_reg  <= '0;
      pend_word <= '0;
      pend_flag <= 1'b0;
      out_valid <= 1'b0;
      out1_re   <= '0;
      out1_im   <= '0;
      out2_re   <= '0;
      out2_im   <= '0;
      phase_out <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out1_re <= in1_re;
        out1_im <= in1_im;
        out2_re <= in2_re;
        out2_im <= in2_im;
      end

      if (nco_clear) begin
        // The sample of the clearing cycle still carries the running phase.
        if (in_valid) begin
          phase_out <= acc[FREQ_W-1 -: PHASE_W];
        end
        state     <= IDLE;
        locked    <= 1'b0;
        acc       <= '0;
        freq_reg  <= '0;
        pend_flag <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid) begin
              phase_out <= '0;
            end
            if (freq_valid) begin
              state     <= RUN;
              locked    <= 1'b1;
              freq_reg  <= freq_word;
              pend_flag <= 1'b0;
              // A coinciding frame start opens the frame at phase 0, so the
              // accumulator is already one step ahead for sample 1.
              acc       <= (in_valid && frame_start) ? freq_word : '0;
            end
          end

          RUN: begin
            if (in_valid && frame_start) begin
              phase_out <= '0;
              freq_reg  <= f_eff;
              acc       <= f_eff;
              pend_flag <= 1'b0;
            end else begin
              if (in_valid) begin
                phase_out <= acc[FREQ_W-1 -: PHASE_W];
                acc       <= acc + freq_reg;
              end
              if (freq_valid) begin
                pend_word <= freq_word;
                pend_flag <= 1'b1;
              end
            end
          end

          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cfo_nco.sv
// tb_cfo_nco: directed scenarios plus a randomized run against a frame-level
// reference model (phase of sample n = top bits of n*f mod 2^FREQ_W).
module tb_cfo_nco;
  localparam int DW = 16;
  localparam int PW = 16;
  localparam int FW = 20;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 freq_valid, nco_clear, in_valid, frame_start;
  logic signed [FW-1:0] freq_word;
  logic signed [DW-1:0] in1_re, in1_im, in2_re, in2_im;
  logic                 out_valid, locked;
  logic signed [DW-1:0] out1_re, out1_im, out2_re, out2_im;
  logic signed [PW-1:0] phase_out;

  int checks = 0;
  int errors = 0;

  cfo_nco #(.DATA_W(DW), .PHASE_W(PW), .FREQ_W(FW)) dut (
    .clk(clk), .rst_n(rst_n),
    .freq_valid(freq_valid), .freq_word(freq_word), .nco_clear(nco_clear),
    .in_valid(in_valid), .frame_start(frame_start),
    .in1_re(in1_re), .in1_im(in1_im), .in2_re(in2_re), .in2_im(in2_im),
    .out_valid(out_valid),
    .out1_re(out1_re), .out1_im(out1_im), .out2_re(out2_re), .out2_im(out2_im),
    .phase_out(phase_out), .locked(locked)
  );

  always #5 clk = ~clk;

  // Reference phase: sample n of a frame with increment f.
  function automatic logic [PW-1:0] ref_phase(input int unsigned n, input logic [FW-1:0] f);
    longint unsigned p;
    logic [FW-1:0]   m;
    p = 64'(n) * 64'(f);
    m = FW'(p);
    return m[FW-1 -: PW];
  endfunction

  // One clock of stimulus; returns #1 after the edge that captured it.
  task automatic drive(input logic iv, input logic fs, input logic fv,
                       input logic [FW-1:0] fw, input logic clr);
    in_valid = iv; frame_start = fs; freq_valid = fv; freq_word = fw; nco_clear = clr;
    if (iv) begin
      in1_re = DW'($urandom); in1_im = DW'($urandom);
      in2_re = DW'($urandom); in2_im = DW'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; frame_start = 1'b0; freq_valid = 1'b0; nco_clear = 1'b0;
  endtask

  task automatic start_nco(input logic [FW-1:0] fw);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, fw, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({out_valid, locked, phase_out, out1_re, out1_im, out2_re, out2_im} !== '0) begin
      errors++;
      $display("FAIL reset: valid=%b locked=%b phase=%0d d1re=%0d, expected all zero",
               out_valid, locked, phase_out, out1_re);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_passthrough;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i == 0, 1'b0, '0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || phase_out !== 16'sd0 || locked !== 1'b0 ||
          {out1_re, out1_im, out2_re, out2_im} !== {in1_re, in1_im, in2_re, in2_im}) begin
        errors++;
        $display("FAIL idle[%0d]: valid=%b phase=%0d locked=%b d1re=%0d, expected 1/0/0 d1re=%0d",
                 i, out_valid, phase_out, locked, out1_re, in1_re);
      end
    end
  endtask

  task automatic test_basic_slope;
    start_nco(20'd16);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, i == 0, 1'b0, '0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || phase_out !== PW'(i) || locked !== 1'b1 ||
          {out1_re, out1_im, out2_re, out2_im} !== {in1_re, in1_im, in2_re, in2_im}) begin
        errors++;
        $display("FAIL slope[%0d]: valid=%b phase=%0d locked=%b, expected 1/%0d/1 with data",
                 i, out_valid, phase_out, locked, i);
      end
    end
  endtask

  task automatic test_wrap;
    logic signed [PW-1:0] e [5] = '{16'sd0, 16'sd16384, -16'sd32768, -16'sd16384, 16'sd0};
    start_nco(20'h40000);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, i == 0, 1'b0, '0, 1'b0);
      checks++;
      if (phase_out !== e[i]) begin
        errors++;
        $display("FAIL wrap[%0d]: phase=%0d, expected %0d", i, phase_out, e[i]);
      end
    end
  endtask

  task automatic test_neg_slope_gaps;
    logic signed [PW-1:0] hold_ph;
    logic [4*DW-1:0]      hold_d;
    start_nco(20'hFFFF0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, 1'b0, '0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || phase_out !== -PW'(i)) begin
        errors++;
        $display("FAIL negslope[%0d]: valid=%b phase=%0d, expected 1/%0d", i, out_valid, phase_out, -i);
      end
      hold_ph = phase_out;
      hold_d  = {in1_re, in1_im, in2_re, in2_im};
      for (int g = 0; g < (i % 2) + 1; g++) begin
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || phase_out !== hold_ph ||
            {out1_re, out1_im, out2_re, out2_im} !== hold_d) begin
          errors++;
          $display("FAIL gap[%0d]: valid=%b phase=%0d, expected 0/%0d with held data",
                   i, out_valid, phase_out, hold_ph);
        end
      end
    end
  endtask

  task automatic test_frame_atomic;
    int e1 [7] = '{0, 1, 2, 3, 4, 5, 6};
    start_nco(20'd16);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, i == 0, i == 3, 20'd32, 1'b0);
      checks++;
      if (phase_out !== PW'(e1[i])) begin
        errors++;
        $display("FAIL atomic_mid[%0d]: phase=%0d, expected %0d", i, phase_out, e1[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i == 0, 1'b0, '0, 1'b0);
      checks++;
      if (phase_out !== PW'(2 * i)) begin
        errors++;
        $display("FAIL atomic_next[%0d]: phase=%0d, expected %0d", i, phase_out, 2 * i);
      end
    end
    // Coincident update back to 1/sample, then to 2/sample.
    for (int k = 1; k <= 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        drive(1'b1, i == 0, i == 0, FW'(16 * k), 1'b0);
        checks++;
        if (phase_out !== PW'(k * i)) begin
          errors++;
          $display("FAIL atomic_coinc[%0d][%0d]: phase=%0d, expected %0d", k, i, phase_out, k * i);
        end
      end
    end
    // Two pending updates in one frame: the last one is adopted.
    drive(1'b0, 1'b0, 1'b1, 20'd48, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 20'd80, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i == 0, 1'b0, '0, 1'b0);
      checks++;
      if (phase_out !== PW'(5 * i)) begin
        errors++;
        $display("FAIL atomic_last[%0d]: phase=%0d, expected %0d", i, phase_out, 5 * i);
      end
    end
  endtask

  task automatic test_clear;
    start_nco(20'd16);
    for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || phase_out !== 16'sd4 || locked !== 1'b0 ||
        {out1_re, out1_im, out2_re, out2_im} !== {in1_re, in1_im, in2_re, in2_im}) begin
      errors++;
      $display("FAIL clear_sample: valid=%b phase=%0d locked=%b, expected 1/4/0 with data",
               out_valid, phase_out, locked);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
      checks++;
      if (phase_out !== 16'sd0 || locked !== 1'b0) begin
        errors++;
        $display("FAIL clear_after[%0d]: phase=%0d locked=%b, expected 0/0", i, phase_out, locked);
      end
    end
  endtask

  task automatic test_reset_midframe;
    start_nco(20'd16);
    for (int i = 0; i < 3; i++) drive(1'b1, i == 0, 1'b0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, locked, phase_out, out1_re, out1_im, out2_re, out2_im} !== '0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b locked=%b phase=%0d, expected all zero immediately",
               out_valid, locked, phase_out);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
      checks++;
      if (phase_out !== 16'sd0 || locked !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL reset_after[%0d]: phase=%0d locked=%b valid=%b, expected 0/0/1",
                 i, phase_out, locked, out_valid);
      end
    end
    drive(1'b0, 1'b0, 1'b1, 20'd16, 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL relock: locked=%b, expected 1", locked);
    end
  endtask

  task automatic test_random;
    bit              run, pend, iv, fs, fv, clr;
    logic [FW-1:0]   f, pv, fw;
    int unsigned     n;
    logic            e_valid, e_locked;
    logic [PW-1:0]   e_ph;
    logic [4*DW-1:0] e_d;
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run = 0; pend = 0; f = '0; pv = '0; n = 0;
    e_valid = 0; e_locked = 0; e_ph = '0; e_d = '0;
    for (int c = 0; c < 600; c++) begin
      iv  = $urandom_range(0, 9) < 7;
      fs  = iv && ($urandom_range(0, 9) == 0);
      fv  = $urandom_range(0, 11) == 0;
      clr = $urandom_range(0, 59) == 0;
      fw  = ($urandom_range(0, 1) == 0) ? FW'($urandom) : FW'($urandom_range(0, 64));
      if (!run && fv) fs = 0;
      e_valid = iv;
      if (clr) begin
        if (iv) e_ph = run ? ref_phase(n, f) : '0;
        run = 0; pend = 0; f = '0; n = 0;
      end else if (!run) begin
        if (iv) e_ph = '0;
        if (fv) begin run = 1; f = fw; pend = 0; n = 0; end
      end else if (iv && fs) begin
        f = fv ? fw : (pend ? pv : f);
        pend = 0; e_ph = '0; n = 1;
      end else begin
        if (iv) begin e_ph = ref_phase(n, f); n++; end
        if (fv) begin pend = 1; pv = fw; end
      end
      e_locked = run;
      drive(iv, fs, fv, fw, clr);
      if (iv) e_d = {in1_re, in1_im, in2_re, in2_im};
      checks++;
      if (out_valid !== e_valid || locked !== e_locked || phase_out !== e_ph) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: valid=%b locked=%b phase=%0d, expected %b/%b/%0d",
                 c, out_valid, locked, phase_out, e_valid, e_locked, $signed(e_ph));
      end
      checks++;
      if ({out1_re, out1_im, out2_re, out2_im} !== e_d) begin
        errors++;
        $display("FAIL rand_data[%0d]: got %h, expected %h", c,
                 {out1_re, out1_im, out2_re, out2_im}, e_d);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; freq_valid = 1'b0; freq_word = '0; nco_clear = 1'b0;
    in_valid = 1'b0; frame_start = 1'b0;
    in1_re = '0; in1_im = '0; in2_re = '0; in2_im = '0;
    test_reset;
    test_idle_passthrough;
    test_basic_slope;
    test_wrap;
    test_neg_slope_gaps;
    test_frame_atomic;
    test_clear;
    test_reset_midframe;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfo_nco.md
# cfo_nco

Phase generator and data aligner that sits directly upstream of the CFO rotator. It takes a per-sample phase-increment word from the CFO estimator and accumulates it over each frame. For every valid two-antenna sample it emits the sample together with its compensation phase, both in the same cycle, so the rotator can apply them without further alignment. Increment updates are frame-atomic: a new estimate arriving mid-frame never changes the phase slope within that frame.

## Interface
- DATA_W, 16, sample component width (signed)
- PHASE_W, 16, output phase width; full scale 2^PHASE_W = 2π, two's complement, so -π maps to -2^(PHASE_W-1)
- FREQ_W, 20, accumulator and increment width; must satisfy FREQ_W >= PHASE_W
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- freq_valid  in  1  single-cycle strobe; freq_word is valid
- freq_word  in  FREQ_W  signed phase increment per sample (LSB = 2π/2^FREQ_W)
- nco_clear  in  1  synchronous clear back to IDLE
- in_valid  in  1  sample strobe
- frame_start  in  1  marks the first sample of a frame; only meaningful when in_valid=1
- in1_re, in1_im, in2_re, in2_im  in  DATA_W each  antenna 1/2 samples (signed)
- out_valid  out  1  output strobe
- out1_re, out1_im, out2_re, out2_im  out  DATA_W each  delayed samples
- phase_out  out  PHASE_W  signed compensation phase for the sample on the out bus
- locked  out  1  1 while in RUN

## Operation
- Registers:
  - acc[FREQ_W-1:0], the phase accumulator
  - freq_reg, the active increment
  - pend_word and pend_flag, the pending increment
  - state ∈ {IDLE, RUN}
- IDLE:
  - freq_reg=0, acc=0; samples pass through with phase_out=0.
  - freq_valid: freq_reg<=freq_word, acc<=0, pend_flag<=0, state->RUN. The next valid sample gets phase 0.
- RUN:
  - freq_valid: pend_word<=freq_word, pend_flag<=1. A later freq_valid before the frame boundary overwrites pend_word (last one wins).
- Per sample with in_valid=1 and frame_start=0:
  - phase_out <= acc[FREQ_W-1 -: PHASE_W], truncated.
  - acc <= acc + freq_reg, wrapping modulo 2^FREQ_W with no saturation.
- Per sample with in_valid=1 and frame_start=1:
  - phase_out <= 0.
  - The effective increment is f_eff = pend_word if pend_flag, else freq_reg.
  - freq_reg <= f_eff, acc <= f_eff, pend_flag <= 0.
  - Result: sample n of a frame (n=0,1,...) has phase top_bits(n·f_eff mod 2^FREQ_W).
- Simultaneous freq_valid and frame_start in RUN: freq_word bypasses the pending register and is f_eff for that frame.
- Simultaneous freq_valid and frame_start in IDLE: the freq_valid rule applies, so the frame starts at phase 0 with freq_word.
- in_valid=0: acc, freq_reg and the data outputs hold; out_valid=0.
- frame_start with in_valid=0 is ignored.
- nco_clear has priority over every other input that cycle: state->IDLE, acc=0, freq_reg=0, pend_flag=0.
  - The sample presented in that cycle is still forwarded, with phase_out = the current acc top bits.
- locked = (state==RUN), registered.

## Timing
- Latency is 1 cycle: out_valid(t+1)=in_valid(t), and data and phase_out(t+1) belong to the sample at t.
- Throughput is one sample per cycle, with no back-pressure.
- Reset values: out_valid=0, all out*_re/_im=0, phase_out=0, locked=0, state=IDLE, acc=0, freq_reg=0, pend_flag=0.
- Reset mid-frame: outputs clear immediately (asynchronously).
  - After rst_n deasserts, the block is in IDLE and emits phase 0 until the next freq_valid.
- freq_valid takes effect on sample timing only as defined above. It never alters phase_out for a sample already accepted.

## Test plan
- Basic slope (FREQ_W=20, PHASE_W=16): freq_valid freq_word=16, then 5 contiguous samples with frame_start on the first -> phase_out 0,1,2,3,4, each one cycle after its input, with data unchanged.
- Wrap: freq_word=0x40000 (quarter turn), 5 samples -> phase_out 0,16384,-32768,-16384,0.
- Negative slope: freq_word=-16 -> phase_out 0,-1,-2,-3. With in_valid gaps inserted, the phase sequence is identical, out_valid mirrors the gaps, and outputs hold during gaps.
- Frame-atomic update:
  - Running with f=16, freq_valid with 32 arrives mid-frame at sample 3 -> phases continue 4,5,6.
  - At the next frame_start -> 0,2,4.
  - Repeat with freq_valid coincident with frame_start -> new frame uses 2/sample immediately.
- nco_clear and reset:
  - nco_clear mid-frame -> locked falls next cycle and subsequent phases are 0.
  - rst_n asserted mid-frame -> all outputs 0 immediately; after release, phase 0 until freq_valid.
- IDLE passthrough: samples with no freq_valid -> phase_out 0, locked 0, data delayed 1 cycle.
